regbank_write_arbiter: RTL and testbench

//   Owns the single write port of the 32-entry register bank and shares it among

---
 rtl/regbank_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter
//
// Owns the single write port of the register bank. Three writeback requesters
// (ALU result, memory load, input port) share it round-robin. The bank has no
// reset of its own, so after reset this block sweeps every entry to zero while
// holding the core stalled via Busy. It also keeps a jal link update from being
// clobbered: a same-cycle request to the link register is held off until JalIn
// drops.
//
// Ports
//   Clock                        rising-edge clock
//   Resetn                       synchronous, active-low reset
//   AluReq/AluAddr/AluData       ALU writeback request, held until AluGnt
//   AluGnt                       ALU request accepted this cycle
//   MemReq/MemAddr/MemData       load writeback request, held until MemGnt
//   MemGnt                       load request accepted this cycle
//   InReq/InAddr/InData          input-port request, held until InGnt
//   InGnt                        input-port request accepted this cycle
//   JalIn                        core requests link write this cycle
//   JalOut                       bank jal input
//   Write/AddrWrite/DataIn       bank write enable, address and data
//   Busy                         clear sweep in progress, core must stall
// -----------------------------------------------------------------------------
module regbank_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              AluReq,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluGnt,
    input  logic              MemReq,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemGnt,
    input  logic              InReq,
    input  logic [ADDR_W-1:0] InAddr,
    input  logic [DATA_W-1:0] InData,
    output logic              InGnt,
    input  logic              JalIn,
    output logic              JalOut,
    output logic              Write,
    output logic [ADDR_W-1:0] AddrWrite,
    output logic [DATA_W-1:0] DataIn,
    output logic              Busy
);

    // One spare bit so the sweep counter can never wrap back to zero.
    localparam int CNT_W = $clog2(NUM_REGS) + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_IN  = 2'd2
    } src_t;

    // Round-robin successor: ALU -> MEM -> IN -> ALU.
    function automatic src_t next_src(input src_t s);
        case (s)
            SRC_ALU: return SRC_MEM;
            SRC_MEM: return SRC_IN;
            default: return SRC_ALU;
        endcase
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   clr_cnt;
    src_t               ptr;

    logic               alu_elig, mem_elig, in_elig;
    logic               any_gnt;
    src_t               gnt_src;
    src_t               cand;
    logic               hit;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               run_active;
    logic               clearing;
    logic               grant_ok;

    // A request to the link register must wait while jal owns that register.
    assign alu_elig = AluReq && !(JalIn && AluAddr == ADDR_W'(LINK_REG));
    assign mem_elig = MemReq && !(JalIn && MemAddr == ADDR_W'(LINK_REG));
    assign in_elig  = InReq  && !(JalIn && InAddr  == ADDR_W'(LINK_REG));

    // Walk the three requesters starting at the pointer; first eligible wins.
    // NOTE: every variable written in always_comb gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        any_gnt = 1'b0;
        gnt_src = SRC_ALU;
        cand    = ptr;
        hit     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (cand)
                SRC_ALU: hit = alu_elig;
                SRC_MEM: hit = mem_elig;
                default: hit = in_elig;
            endcase
            if (!any_gnt && hit) begin
                any_gnt = 1'b1;
                gnt_src = cand;
            end
            cand = next_src(cand);
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (gnt_src)
            SRC_ALU: begin
                sel_addr = AluAddr;
                sel_data = AluData;
            end
            SRC_MEM: begin
                sel_addr = MemAddr;
                sel_data = MemData;
            end
            default: begin
                sel_addr = InAddr;
                sel_data = InData;
            end
        endcase
    end

    // State is registered; the outputs are decoded from it combinationally
    // because a grant must answer its request in the same cycle. Resetn gates
    // everything so the bank sees no write while reset is held.
    assign run_active = Resetn && (state == ST_RUN);
    assign clearing   = Resetn && (state == ST_CLEAR);
    assign grant_ok   = run_active && any_gnt;

    assign AluGnt = grant_ok && (gnt_src == SRC_ALU);
    assign MemGnt = grant_ok && (gnt_src == SRC_MEM);
    assign InGnt  = grant_ok && (gnt_src == SRC_IN);

    // r0 is hardwired zero: the grant still happens, the write is dropped.
    assign Write     = clearing || (grant_ok && sel_addr != '0);
    assign AddrWrite = clearing ? clr_cnt[ADDR_W-1:0] : (grant_ok ? sel_addr : '0);
    assign DataIn    = grant_ok ? sel_data : '0;
    assign JalOut    = run_active && JalIn;
    assign Busy      = !Resetn || (state == ST_CLEAR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ptr     <= SRC_ALU;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_W'(NUM_REGS - 1))
                        state <= ST_RUN;
                end
                default: begin
                    if (any_gnt)
                        ptr <= next_src(gnt_src);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbank_write_arbiter
//
// Drives regbank_write_arbiter with directed steps followed by random traffic.
// An emulated register bank sits on the DUT write/jal outputs; a reference
// model (rotating-priority pick over the three requesters, expected register
// file) predicts every output and every register value.
// -----------------------------------------------------------------------------
module tb_regbank_write_arbiter;

    logic        Clock;
    logic        Resetn;
    logic        AluReq, MemReq, InReq;
    logic [4:0]  AluAddr, MemAddr, InAddr;
    logic [31:0] AluData, MemData, InData;
    logic        AluGnt, MemGnt, InGnt;
    logic        JalIn, JalOut, Write, Busy;
    logic [4:0]  AddrWrite;
    logic [31:0] DataIn;

    // Requester state: index 0 = ALU, 1 = MEM, 2 = IN.
    logic        req_v  [3];
    logic [4:0]  addr_v [3];
    logic [31:0] data_v [3];

    logic [31:0] pc;
    logic [31:0] bank     [32];
    logic [31:0] exp_regs [32];
    int          m_ptr;
    int          checks;
    int          errors;

    assign AluReq  = req_v[0];
    assign MemReq  = req_v[1];
    assign InReq   = req_v[2];
    assign AluAddr = addr_v[0];
    assign MemAddr = addr_v[1];
    assign InAddr  = addr_v[2];
    assign AluData = data_v[0];
    assign MemData = data_v[1];
    assign InData  = data_v[2];

    regbank_write_arbiter dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .AluReq    (AluReq),
        .AluAddr   (AluAddr),
        .AluData   (AluData),
        .AluGnt    (AluGnt),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemGnt    (MemGnt),
        .InReq     (InReq),
        .InAddr    (InAddr),
        .InData    (InData),
        .InGnt     (InGnt),
        .JalIn     (JalIn),
        .JalOut    (JalOut),
        .Write     (Write),
        .AddrWrite (AddrWrite),
        .DataIn    (DataIn),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register bank: plain array, no reset, jal writes PC+1 into r31.
    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'hA5A5_0000 | i;
    end
    always @(posedge Clock) begin
        if (Write)  bank[AddrWrite] <= DataIn;
        if (JalOut) bank[31]        <= pc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference pick: first requester from the pointer onward that asks and
    // is not blocked by a jal on the link register.
    function automatic int pick();
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_ptr + k) % 3;
            if (req_v[s] && !(JalIn && addr_v[s] == 5'd31)) return s;
        end
        return -1;
    endfunction

    // Outputs while Resetn is held low.
    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_write"}, {31'd0, Write}, 32'd0);
        check({tag, "_busy"},  {31'd0, Busy},  32'd1);
        check({tag, "_jal"},   {31'd0, JalOut}, 32'd0);
        check({tag, "_gnt"},   {29'd0, AluGnt, MemGnt, InGnt}, 32'd0);
    endtask

    // Checks n sweep cycles starting at register 0; enter and leave at negedge.
    task automatic sweep(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            check({tag, "_busy"},  {31'd0, Busy},  32'd1);
            check({tag, "_write"}, {31'd0, Write}, 32'd1);
            check({tag, "_addr"},  {27'd0, AddrWrite}, c);
            check({tag, "_data"},  DataIn, 32'd0);
            check({tag, "_gnt"},   {29'd0, AluGnt, MemGnt, InGnt}, 32'd0);
            check({tag, "_jal"},   {31'd0, JalOut}, 32'd0);
            @(negedge Clock);
        end
    endtask

    // One RUN cycle: inputs already set at the negedge; check outputs against
    // the model, let the edge pass, then update model and drop granted requests.
    task automatic step(input string tag);
        int g;
        #1;
        g = pick();
        check({tag, "_alugnt"}, {31'd0, AluGnt}, {31'd0, g == 0});
        check({tag, "_memgnt"}, {31'd0, MemGnt}, {31'd0, g == 1});
        check({tag, "_ingnt"},  {31'd0, InGnt},  {31'd0, g == 2});
        check({tag, "_write"},  {31'd0, Write},  {31'd0, g >= 0 && addr_v[g] != 5'd0});
        check({tag, "_addr"},   {27'd0, AddrWrite}, (g >= 0) ? {27'd0, addr_v[g]} : 32'd0);
        if (g < 0 || addr_v[g] != 5'd0)
            check({tag, "_data"}, DataIn, (g >= 0) ? data_v[g] : 32'd0);
        check({tag, "_jal"},    {31'd0, JalOut}, {31'd0, JalIn});
        check({tag, "_busy"},   {31'd0, Busy},   32'd0);
        @(negedge Clock);
        if (JalIn) begin
            exp_regs[31] = pc + 32'd1;
            check({tag, "_r31link"}, bank[31], exp_regs[31]);
        end
        if (g >= 0) begin
            if (addr_v[g] != 5'd0) exp_regs[addr_v[g]] = data_v[g];
            check({tag, "_reg"}, bank[addr_v[g]], exp_regs[addr_v[g]]);
            m_ptr = (g + 1) % 3;
            req_v[g] = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ptr  = 0;
        pc     = 32'd0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;

        // Reset with traffic and jal present: nothing may leak out.
        Resetn = 1'b0;
        JalIn  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req_v[s]  = 1'b1;
            data_v[s] = 32'h1111_0000 + s;
        end
        addr_v[0] = 5'd31;
        addr_v[1] = 5'd0;
        addr_v[2] = 5'd7;
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");

        // Release and abort the sweep after 10 cycles; it must restart at 0.
        Resetn = 1'b1;
        sweep("sweep_a", 10);
        Resetn = 1'b0;
        check_reset_outputs("midreset");
        @(negedge Clock);
        Resetn = 1'b1;
        // Full sweep with jal and requests active: both ignored while clearing.
        sweep("sweep_b", 32);

        JalIn = 1'b0;
        for (int s = 0; s < 3; s++) req_v[s] = 1'b0;
        #1;
        check("run_busy",  {31'd0, Busy},  32'd0);
        check("run_write", {31'd0, Write}, 32'd0);
        for (int i = 0; i < 32; i++) check("cleared_reg", bank[i], 32'd0);

        // Three simultaneous requests: ALU, MEM, IN on consecutive cycles.
        @(negedge Clock);
        for (int s = 0; s < 3; s++) begin
            req_v[s]  = 1'b1;
            addr_v[s] = 5'(3 + s);
            data_v[s] = $urandom;
        end
        step("rr0");
        check("rr0_aludone", {31'd0, req_v[0]}, 32'd0);
        step("rr1");
        check("rr1_memdone", {31'd0, req_v[1]}, 32'd0);
        step("rr2");
        check("rr2_indone", {31'd0, req_v[2]}, 32'd0);

        // jal blocks an ALU write to the link register, then lets it through.
        JalIn     = 1'b1;
        pc        = 32'h40;
        req_v[0]  = 1'b1;
        addr_v[0] = 5'd31;
        data_v[0] = 32'hCAFE_F00D;
        step("jal_block");
        check("jal_r31", bank[31], 32'h41);
        check("jal_pending", {31'd0, req_v[0]}, 32'd1);
        JalIn = 1'b0;
        step("jal_retry");
        check("jal_retry_r31", bank[31], 32'hCAFE_F00D);

        // r0 write: granted but dropped, pointer still moves on to IN.
        req_v[1]  = 1'b1;
        addr_v[1] = 5'd0;
        data_v[1] = 32'h0000_DEAD;
        step("r0");
        check("r0_stays", bank[0], 32'd0);
        for (int s = 0; s < 3; s++) begin
            req_v[s]  = 1'b1;
            addr_v[s] = 5'(10 + s);
            data_v[s] = $urandom;
        end
        step("after_r0");
        check("after_r0_in_first", {31'd0, req_v[2]}, 32'd0);
        step("drain0");
        step("drain1");

        // Random traffic: holds, withdrawals, r0 and link-register targets.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int s = 0; s < 3; s++) begin
                if (!req_v[s]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_v[s] = 1'b1;
                        case ($urandom_range(0, 7))
                            0, 1:    addr_v[s] = 5'd31;
                            2:       addr_v[s] = 5'd0;
                            default: addr_v[s] = 5'($urandom_range(0, 31));
                        endcase
                        data_v[s] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_v[s] = 1'b0;
                end
            end
            JalIn = ($urandom_range(0, 2) == 0);
            pc    = $urandom;
            step("rand");
        end

        JalIn = 1'b0;
        for (int s = 0; s < 3; s++) req_v[s] = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 32; i++) check("final_reg", bank[i], exp_regs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
